// File: rtl/mpadder_arb_pkg.sv
// mpadder_arb_pkg: shared widths and FSM encoding for the mpadder arbiter
package mpadder_arb_pkg;
  localparam int OP_W = 1027;
  localparam int RES_W = OP_W + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
endpackage

// File: rtl/mpadder_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set req bit at or after ptr
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);
  logic [PW-1:0] c;
  always_comb begin
    idx = '0;
    c = '0;
    for (int i = N - 1; i >= 0; i--) begin
      c = PW'((int'(ptr) + i) % N);
      if (req[c]) idx = c;
    end
  end
  assign any = |req;
  assign grant = any ? (N'(1) << idx) : '0;
endmodule

// File: rtl/mpadder_arbiter.sv
// mpadder_arbiter: round-robin sharing of one mpadder among NUM_REQ requesters.
// Define MPADDER_ARB_TIMEOUT_EN to enable the WAIT-state timeout with error response.
module mpadder_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int OP_W = mpadder_arb_pkg::OP_W,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_sub,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      ack,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [OP_W:0]           rsp_data,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    add_start,
  output logic                    add_sub,
  output logic [OP_W-1:0]         add_a,
  output logic [OP_W-1:0]         add_b,
  input  logic [OP_W:0]           add_result,
  input  logic                    add_done
);
  import mpadder_arb_pkg::*;
  localparam int PW = $clog2(NUM_REQ);
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("mpadder_arbiter: unsupported NUM_REQ or TIMEOUT");
  end
  state_t state, state_n;
  logic [PW-1:0] ptr, owner, idx;
  logic [NUM_REQ-1:0] grant;
  logic any, expire, finish;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req(req),
    .ptr(ptr),
    .grant(grant),
    .idx(idx),
    .any(any)
  );
`ifdef MPADDER_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer;
  always_ff @(posedge clk) begin
    if (!resetn || state != WAIT) timer <= '0;
    else timer <= timer + 1'b1;
  end
  // a done arriving on the expiry cycle still wins
  assign expire = state == WAIT && !add_done && timer == TW'(TIMEOUT - 1);
`else
  assign expire = 1'b0;
`endif
  assign finish = state == WAIT && (add_done || expire);
  always_comb begin
    state_n = IDLE;
    if (state == IDLE) state_n = any ? ISSUE : IDLE;
    else if (state == ISSUE) state_n = WAIT;
    else if (state == WAIT) state_n = finish ? IDLE : WAIT;
  end
  // outputs are forced low during reset even before the state register clears
  assign ack = (resetn && state == IDLE) ? grant : '0;
  assign busy = resetn && state != IDLE;
  assign add_start = resetn && state == ISSUE;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      add_a <= '0;
      add_b <= '0;
      add_sub <= 1'b0;
      rsp_valid <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_n;
      rsp_valid <= finish ? (NUM_REQ'(1) << owner) : '0;
      if (state == IDLE && any) begin
        owner <= idx;
        add_a <= req_a[idx*OP_W +: OP_W];
        add_b <= req_b[idx*OP_W +: OP_W];
        add_sub <= req_sub[idx];
      end
      if (finish) begin
        rsp_data <= add_done ? add_result : '0;
        rsp_err <= !add_done;
        ptr <= (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mpadder_arbiter.sv
// tb_mpadder_arbiter: directed and random checks of arbitration, handshake and result routing
module tb_mpadder_arbiter;
  localparam int NR = 3;
  localparam int W = 1027;
  localparam int RW = W + 1;
  logic clk = 0, resetn = 0;
  logic [NR-1:0] req = '0, req_sub = '0;
  logic [NR*W-1:0] req_a = '0, req_b = '0;
  logic [NR-1:0] ack, rsp_valid;
  logic [RW-1:0] rsp_data, add_result = '0, mres;
  logic rsp_err, busy, add_start, add_sub, add_done = 0;
  logic [W-1:0] add_a, add_b;
  logic [W-1:0] opa [NR], opb [NR];
  logic ops [NR];
  logic [W-1:0] m2;
  int errors = 0, checks = 0, lat = 3, ptr_m = 0, n, nreq;
  bit stuck = 0, bad;

  mpadder_arbiter #(.NUM_REQ(NR), .OP_W(W), .TIMEOUT(15)) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_sub(req_sub), .req_a(req_a), .req_b(req_b),
    .ack(ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .add_start(add_start), .add_sub(add_sub), .add_a(add_a), .add_b(add_b),
    .add_result(add_result), .add_done(add_done)
  );

  always #5 clk = ~clk;

  // behavioural mpadder: answers each start after lat cycles unless stuck
  initial forever begin
    @(posedge clk); #1;
    if (add_start && !stuck) begin
      mres = add_sub ? {1'b0, add_a} - {1'b0, add_b} : {1'b0, add_a} + {1'b0, add_b};
      repeat (lat) @(posedge clk);
      #1 add_result = mres; add_done = 1;
      @(posedge clk); #1 add_done = 0; add_result = '0;
    end
  end

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h..%h expected %h..%h", tag, obs[RW-1:RW-32], obs[63:0], exp[RW-1:RW-32], exp[63:0]);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] r, input int p);
    for (int k = 0; k < NR; k++) if (r[(p + k) % NR]) return (p + k) % NR;
    return 0;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] v = '0;
    repeat (33) v = {v[W-33:0], 32'($urandom)};
    return v;
  endfunction

  task automatic raise(input int r, input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
    opa[r] = a; opb[r] = b; ops[r] = sub;
    req_a[r*W +: W] = a; req_b[r*W +: W] = b; req_sub[r] = sub; req[r] = 1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_add_start"}, add_start, 0);
    chk({tag, "_add_sub"}, add_sub, 0);
    chk({tag, "_add_a"}, add_a, 0);
    chk({tag, "_add_b"}, add_b, 0);
  endtask

  // serves the requester the round-robin rule says should win next
  task automatic serve();
    int who, k;
    logic [RW-1:0] exp;
    bit q;
    who = pick(req, ptr_m);
    k = 0;
    #1;
    while (ack == 0 && k < 100) begin @(posedge clk); #2; k++; end
    chk("ack", ack, 1 << who);
    chk("busy_at_ack", busy, 0);
    @(posedge clk); #1 req[who] = 0; #1;
    chk("add_start", add_start, 1);
    chk("add_a", add_a, opa[who]);
    chk("add_b", add_b, opb[who]);
    chk("add_sub", add_sub, ops[who]);
    chk("busy_issue", busy, 1);
    q = 0; k = 0;
    @(posedge clk); #2;
    while (rsp_valid == 0 && k < 200) begin
      if (ack != 0 || add_start) q = 1;
      @(posedge clk); #2; k++;
    end
    chk("quiet_while_busy", q, 0);
    exp = ops[who] ? {1'b0, opa[who]} - {1'b0, opb[who]} : {1'b0, opa[who]} + {1'b0, opb[who]};
    chk("rsp_valid", rsp_valid, 1 << who);
    chk("rsp_data", rsp_data, exp);
    chk("rsp_err", rsp_err, 0);
    chk("busy_done", busy, 0);
    ptr_m = (who + 1) % NR;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    resetn = 1;
    @(posedge clk); #1;
    raise(0, 0, 5, 3); serve();
    chk("t1_sum", rsp_data, 8);
    @(posedge clk); #1;
    raise(1, 1, 3, 5); serve();
    m2 = '1; m2 = m2 - 1'b1;
    chk("t2_msb", rsp_data[W], 1);
    chk("t2_low", rsp_data[W-1:0], m2);
    // fresh pointer for the 0,1,2 ordering run
    @(posedge clk); #1 resetn = 0; ptr_m = 0;
    @(posedge clk); #1 resetn = 1;
    for (int r = 0; r < NR; r++) raise(r, 1'($urandom), rnd(), rnd());
    repeat (3) serve();
    @(posedge clk); #1;
    raise(0, 0, rnd(), rnd()); serve();
    @(posedge clk); #1;
    raise(0, 1, rnd(), rnd()); raise(2, 0, rnd(), rnd()); serve();
    #1 raise(2, 1, rnd(), rnd()); serve();
    serve();
    // reset while the adder is still working; its late done must be ignored
    lat = 8;
    @(posedge clk); #1 raise(1, 0, rnd(), rnd());
    n = 0; #1;
    while (ack == 0 && n < 50) begin @(posedge clk); #2; n++; end
    chk("t5_ack", ack, 3'b010);
    @(posedge clk); #1 req[1] = 0;
    @(posedge clk); #1 resetn = 0;
    @(posedge clk); #1 chk_zero("mid_reset");
    resetn = 1; ptr_m = 0; bad = 0;
    repeat (15) begin @(posedge clk); #2; if (rsp_valid != 0 || busy) bad = 1; end
    chk("stale_done_ignored", bad, 0);
    lat = 3;
    raise(2, 1, rnd(), rnd()); serve();
    for (int it = 0; it < 12; it++) begin
      @(posedge clk); #1;
      lat = $urandom_range(1, 6);
      nreq = $urandom_range(1, 7);
      for (int r = 0; r < NR; r++) if (nreq[r]) raise(r, 1'($urandom), rnd(), rnd());
      while (req != 0) serve();
    end
    // adder never answers
    stuck = 1;
    @(posedge clk); #1 raise(0, 0, rnd(), rnd());
    n = 0; #1;
    while (ack == 0 && n < 50) begin @(posedge clk); #2; n++; end
    chk("t6_ack", ack, 3'b001);
    @(posedge clk); #1 req[0] = 0; #1;
    chk("t6_start", add_start, 1);
    n = 0;
    @(posedge clk); #2;
    while (rsp_valid == 0 && n < 40) begin @(posedge clk); #2; n++; end
`ifdef MPADDER_ARB_TIMEOUT_EN
    chk("timeout_cycles", n, 15);
    chk("timeout_valid", rsp_valid, 3'b001);
    chk("timeout_err", rsp_err, 1);
    chk("timeout_data", rsp_data, 0);
    chk("timeout_busy", busy, 0);
`else
    chk("no_timeout_wait", n, 40);
    chk("no_timeout_busy", busy, 1);
    chk("no_timeout_err", rsp_err, 0);
    @(posedge clk); #1 resetn = 0;
    @(posedge clk); #1 resetn = 1;
    chk("recover_busy", busy, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
